// File: rtl/pos_cell_access_ctrl.sv
// rtl/pos_cell_access_ctrl.sv - cell memory access controller: count-word read, particle streaming, single writes
// Memory read data arrives two cycles after the registered address; the valid/index pipe tracks that latency.
module pos_cell_access_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic                  rd_pause,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  rd_ack,
  output logic                  wr_ack,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_index,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren
);

  typedef enum logic [2:0] {IDLE, CNT_ISSUE, CNT_WAIT, STREAM, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state_q, state_d;
  logic [1:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] particle_count_q, particle_count_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_rden_q, mem_rden_d;
  logic                  mem_wren_q, mem_wren_d;
  logic                  p1_valid_q, p1_valid_d;
  logic [ADDR_WIDTH-1:0] p1_idx_q, p1_idx_d;
  logic                  p1_last_q, p1_last_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_index_q, rd_index_d;
  logic                  rd_last_q, rd_last_d;

  logic                  wr_inflight;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_sat;
  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] issue_lim;

  assign wr_inflight = wr_ack_q | mem_wren_q;
  assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
  assign cnt_sat     = (cnt_raw > CNT_MAX) ? CNT_MAX : cnt_raw;

  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    addr_d           = addr_q;
    particle_count_d = particle_count_q;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    rd_ack_d         = 1'b0;
    wr_ack_d         = 1'b0;
    done_d           = 1'b0;
    mem_address_d    = mem_address_q;
    mem_data_d       = mem_data_q;
    mem_rden_d       = 1'b0;
    mem_wren_d       = 1'b0;
    issue_en         = 1'b0;
    issue_addr       = addr_q;
    issue_lim        = particle_count_q;

    // Address 0 is the count read, never a streamed particle.
    p1_valid_d = mem_rden_q && (mem_address_q != '0);
    p1_idx_d   = mem_address_q;
    p1_last_d  = (mem_address_q == particle_count_q);
    rd_valid_d = p1_valid_q;
    rd_index_d = p1_valid_q ? p1_idx_q : '0;
    rd_last_d  = p1_valid_q && p1_last_q;

    if (wr_ack_q) begin
      mem_wren_d    = 1'b1;
      mem_address_d = wr_addr_q;
      mem_data_d    = wr_data_q;
    end

    case (state_q)
      IDLE: begin
        if (wr_req && !wr_inflight) begin
          wr_ack_d  = 1'b1;
          wr_addr_d = wr_addr;
          wr_data_d = wr_data;
        end else if (rd_req && !wr_inflight) begin
          rd_ack_d = 1'b1;
          state_d  = CNT_ISSUE;
        end
      end
      CNT_ISSUE: begin
        mem_rden_d    = 1'b1;
        mem_address_d = '0;
        wait_d        = 2'd0;
        state_d       = CNT_WAIT;
      end
      CNT_WAIT: begin
        wait_d = wait_q + 2'd1;
        if (wait_q == 2'd2) begin
          particle_count_d = cnt_sat;
          if (cnt_sat == '0) begin
            done_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            // First address goes out while the count is still on mem_q.
            issue_en   = 1'b1;
            issue_addr = ADDR_WIDTH'(1);
            issue_lim  = cnt_sat;
            state_d    = STREAM;
          end
        end
      end
      STREAM: issue_en = 1'b1;
      DRAIN: begin
        done_d = p1_valid_q && p1_last_q;
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue_en) begin
      if (rd_pause) begin
        addr_d = issue_addr;
      end else begin
        mem_rden_d    = 1'b1;
        mem_address_d = issue_addr;
        addr_d        = issue_addr + ADDR_WIDTH'(1);
        if (issue_addr == issue_lim) state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      wait_q           <= '0;
      addr_q           <= '0;
      particle_count_q <= '0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      rd_ack_q         <= 1'b0;
      wr_ack_q         <= 1'b0;
      done_q           <= 1'b0;
      mem_address_q    <= '0;
      mem_data_q       <= '0;
      mem_rden_q       <= 1'b0;
      mem_wren_q       <= 1'b0;
      p1_valid_q       <= 1'b0;
      p1_idx_q         <= '0;
      p1_last_q        <= 1'b0;
      rd_valid_q       <= 1'b0;
      rd_index_q       <= '0;
      rd_last_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      wait_q           <= wait_d;
      addr_q           <= addr_d;
      particle_count_q <= particle_count_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      rd_ack_q         <= rd_ack_d;
      wr_ack_q         <= wr_ack_d;
      done_q           <= done_d;
      mem_address_q    <= mem_address_d;
      mem_data_q       <= mem_data_d;
      mem_rden_q       <= mem_rden_d;
      mem_wren_q       <= mem_wren_d;
      p1_valid_q       <= p1_valid_d;
      p1_idx_q         <= p1_idx_d;
      p1_last_q        <= p1_last_d;
      rd_valid_q       <= rd_valid_d;
      rd_index_q       <= rd_index_d;
      rd_last_q        <= rd_last_d;
    end
  end

  assign rd_ack         = rd_ack_q;
  assign wr_ack         = wr_ack_q;
  assign rd_valid       = rd_valid_q;
  assign rd_last        = rd_last_q;
  assign rd_data        = rd_valid_q ? mem_q : '0;
  assign rd_index       = rd_index_q;
  assign particle_count = particle_count_q;
  assign busy           = (state_q == CNT_WAIT) || (state_q == STREAM) || (state_q == DRAIN);
  assign done           = done_q;
  assign mem_address    = mem_address_q;
  assign mem_data       = mem_data_q;
  assign mem_rden       = mem_rden_q;
  assign mem_wren       = mem_wren_q;

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// tb/tb_pos_cell_access_ctrl.sv - scoreboard bench for pos_cell_access_ctrl with a 2-cycle memory model
module tb_pos_cell_access_ctrl;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0, rd_pause = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem_q = '0;
  logic          rd_ack, wr_ack, rd_valid, rd_last, busy, done, mem_rden, mem_wren;
  logic [DW-1:0] rd_data, mem_data;
  logic [AW-1:0] rd_index, particle_count, mem_address;

  pos_cell_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_pause(rd_pause), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_q(mem_q), .rd_ack(rd_ack), .wr_ack(wr_ack),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data), .rd_index(rd_index),
    .particle_count(particle_count), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int i);
    return {32'(i * 7 + 1), 32'(32'hBEEF0000 | i), 32'(i)};
  endfunction

  // Memory model: bench port for preloading, DUT write port, 2-cycle read latency.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] r1 = '0;
  logic          fill = 1'b0, bw_en = 1'b0;
  logic [AW-1:0] bw_addr = '0;
  logic [DW-1:0] bw_data = '0;
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    else if (bw_en) mem[bw_addr] <= bw_data;
    else if (mem_wren) mem[mem_address] <= mem_data;
    r1    <= mem[mem_address];
    mem_q <= r1;
  end

  logic [255:0] all_outs;
  assign all_outs = 256'({rd_ack, wr_ack, rd_valid, rd_last, rd_data, rd_index, particle_count,
                          busy, done, mem_address, mem_data, mem_rden, mem_wren});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (mem_rden && mem_wren) chk("rden_wren_overlap", 1, 0);
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rd_valid", {248'd0, rd_index}, 0);
      end else begin
        e = sb.pop_front();
        chk("rd_index", rd_index, e.idx);
        chk("rd_data", rd_data, e.data);
        chk("rd_last", rd_last, e.last);
        chk("rd_valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_word(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    bw_en = 1'b1; bw_addr = AW'(a); bw_data = d;
    @(negedge clk);
    bw_en = 1'b0;
  endtask

  task automatic get_ack(output int t);
    t = -1;
    rd_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_ack) begin t = cyc; break; end
    end
    rd_req = 1'b0;
    chk("rd_ack_seen", (t >= 0), 1);
    chk("busy_at_ack", busy, 0);
  endtask

  // Expected issue schedule: one address per cycle from T+4, skipping cycles after a paused cycle.
  task automatic run_stream(input int t, input int n, input int p_rel, input int p_len,
                            input int w_rel, output int t_done);
    exp_t e;
    int   c, exp_done;
    logic seen_wr;
    c = t + 4;
    for (int k = 1; k <= n; k++) begin
      while (p_rel >= 0 && c >= t + p_rel + 1 && c <= t + p_rel + p_len) c++;
      e.idx = k; e.data = pat(k); e.last = (k == n); e.cyc = c + 2;
      sb.push_back(e);
      c++;
    end
    exp_done = (n == 0) ? t + 4 : c + 1;
    t_done   = -1;
    seen_wr  = 1'b0;
    for (int i = 1; i < 600; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("cnt_rden", mem_rden, 1);
        chk("cnt_addr", mem_address, 0);
        chk("busy_start", busy, 1);
      end
      if (i == 4) chk("particle_count", particle_count, n);
      rd_pause = (p_rel >= 0 && i >= p_rel && i < p_rel + p_len);
      if (w_rel >= 0 && i >= w_rel) wr_req = 1'b1;
      seen_wr = seen_wr | wr_ack | mem_wren;
      if (done) begin t_done = cyc; break; end
    end
    rd_pause = 1'b0;
    chk("done_cycle", t_done, exp_done);
    chk("busy_at_done", busy, 1);
    if (w_rel >= 0) chk("wr_blocked_while_busy", seen_wr, 0);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_read(input int n, input int p_rel, input int p_len, input int w_rel,
                          output int t_done);
    int t;
    get_ack(t);
    run_stream(t, n, p_rel, p_len, w_rel, t_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   td, t, tw, tr, twr;
    logic saw_done;
    exp_t e;

    rd_req = 1'b1; wr_req = 1'b1; wr_data = '1; wr_addr = '1;
    @(negedge clk); fill = 1'b1;
    @(negedge clk); fill = 1'b0;
    @(negedge clk);
    chk("reset_outputs", all_outs, 0);
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", all_outs, 0);

    // count = 3, upper bits of the count word must be ignored
    set_word(0, {64'h1234, 32'h0000_0103});
    run_read(3, -1, 0, -1, td);

    // count = 0
    set_word(0, {64'hFFFF, 32'h0000_0100});
    run_read(0, -1, 0, -1, td);

    // count = 5, rd_pause in cycles T+5, T+6 -> indices at T+6,7,10,11,12
    set_word(0, DW'(5));
    run_read(5, 5, 2, -1, td);

    // write request raised mid-stream is held off until IDLE
    wr_addr = AW'(10); wr_data = {32'hCAFE, 32'hF00D, 32'h0BAD};
    set_word(0, DW'(5));
    run_read(5, -1, 0, 5, td);
    t = -1;
    for (int i = 0; i < 10; i++) begin
      if (wr_ack) begin t = cyc; break; end
      @(negedge clk);
    end
    wr_req = 1'b0;
    chk("wr_ack_after_done", t, td + 2);
    @(negedge clk);
    chk("wr_mem_wren", mem_wren, 1);
    chk("wr_mem_addr", mem_address, 10);
    chk("wr_mem_data", mem_data, {32'hCAFE, 32'hF00D, 32'h0BAD});
    @(negedge clk);
    chk("wr_single_cycle", mem_wren, 0);

    // simultaneous write (count word = 2) and read: write first
    wr_addr = '0; wr_data = DW'(2);
    wr_req = 1'b1; rd_req = 1'b1;
    tw = -1; tr = -1; twr = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_wren) begin
        twr = cyc;
        chk("wr0_mem_data", mem_data, 2);
      end
      if (wr_ack && tw < 0) begin tw = cyc; wr_req = 1'b0; end
      if (rd_ack) begin tr = cyc; rd_req = 1'b0; break; end
    end
    chk("wr_before_rd", (tw >= 0 && tw < tr), 1);
    chk("rd_ack_gap", tr - tw, 3);
    chk("wren_after_ack", twr, tw + 1);
    run_stream(tr, 2, -1, 0, -1, td);

    // saturated count, then reset in the middle of the stream
    set_word(0, DW'(250));
    get_ack(t);
    for (int k = 1; k <= PN - 1; k++) begin
      e.idx = k; e.data = pat(k); e.last = (k == PN - 1); e.cyc = t + 5 + k;
      sb.push_back(e);
    end
    tr = -1;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (i == 4) chk("particle_count_sat", particle_count, PN - 1);
      if (rd_valid && rd_index == AW'(4)) begin tr = cyc; break; end
    end
    chk("index4_cycle", tr, t + 9);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_outputs", all_outs, 0);
    sb.delete();
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_done = saw_done | done | rd_valid;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_done = saw_done | done | rd_valid | busy;
    end
    chk("no_done_after_abort", saw_done, 0);
    chk("count_cleared", particle_count, 0);

    set_word(0, DW'(3));
    run_read(3, -1, 0, -1, td);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pos_cell_access_ctrl.md
POS_CELL_ACCESS_CTRL -- requirements
Module: pos_cell_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning the {posz, posy, posx} word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the cell memory address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, meaning the cell memory depth; address 0 is the count word.
REQ-004 SHALL have port clk  in  1  the single clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_req  in  1  stream-cell request, held high until rd_ack.
REQ-007 SHALL have port rd_pause  in  1  when high, the block issues no new stream address.
REQ-008 SHALL have port wr_req  in  1  write request, held high until wr_ack.
REQ-009 SHALL have port wr_addr  in  ADDR_WIDTH  write address; 0 updates the count word.
REQ-010 SHALL have port wr_data  in  DATA_WIDTH  write data.
REQ-011 SHALL have port mem_q  in  DATA_WIDTH  memory read data, valid 2 cycles after the address.
REQ-012 SHALL have port rd_ack, wr_ack  out  1 each  one-cycle acceptance pulses.
REQ-013 SHALL have port rd_valid, rd_last  out  1 each  streamed particle valid / final particle.
REQ-014 SHALL have port rd_data  out  DATA_WIDTH  streamed particle position.
REQ-015 SHALL have port rd_index  out  ADDR_WIDTH  memory address of rd_data (1..N).
REQ-016 SHALL have port particle_count  out  ADDR_WIDTH  count latched from address 0.
REQ-017 SHALL have port busy, done  out  1 each  read sequence active / one-cycle end-of-sequence pulse.
REQ-018 SHALL have port mem_address, mem_data, mem_rden, mem_wren  out  ADDR_WIDTH/DATA_WIDTH/1/1  registered memory controls.

Function
REQ-019 SHALL implement the states IDLE, CNT_ISSUE, CNT_WAIT, STREAM, DRAIN.
REQ-020 In IDLE with wr_req high, the block SHALL grant the write: wr_ack pulses, and next cycle mem_wren=1 with the registered wr_addr/wr_data for exactly one cycle.
REQ-021 In IDLE, wr_req SHALL have priority over rd_req; the read is acked in the first IDLE cycle with no wr_req and no write in flight.
REQ-022 On rd_ack (cycle T), the block SHALL enter CNT_ISSUE and drive mem_address=0 with mem_rden=1 in cycle T+1, then enter CNT_WAIT.
REQ-023 In cycle T+3, the block SHALL latch particle_count from mem_q[ADDR_WIDTH-1:0], saturated to PARTICLE_NUM-1.
REQ-024 If the count is 0, the block SHALL pulse done in cycle T+4 with no rd_valid and return to IDLE.
REQ-025 Otherwise, STREAM SHALL issue addresses 1..count, one per cycle, starting in cycle T+4, skipping every cycle in which rd_pause is high.
REQ-026 Each issued address SHALL produce rd_valid, rd_data=mem_q and rd_index=address exactly 2 cycles later, tracked in a 2-stage valid/index pipe.
REQ-027 rd_last SHALL be high together with rd_valid for index==count only.
REQ-028 After the last address is issued, the block SHALL enter DRAIN, pulse done in the same cycle as rd_last, and return to IDLE in the next cycle.
REQ-029 rd_pause SHALL NOT suppress in-flight data: up to 2 valid words SHALL still emerge after pause asserts.
REQ-030 busy SHALL be high from the cycle after rd_ack through the done cycle inclusive.
REQ-031 wr_req SHALL be ignored (no wr_ack) while busy; memory contents are never written mid-stream.
REQ-032 mem_wren and mem_rden SHALL never be high in the same cycle.
REQ-033 particle_count SHALL hold its value until the next count latch.

Reset
REQ-034 While rst_n is low, the block SHALL force state=IDLE, clear the pipe, and drive all outputs to 0 (mem_rden=0, mem_wren=0, particle_count=0).
REQ-035 Reset asserted mid-sequence SHALL abort the sequence with no done pulse, and in-flight mem_q SHALL be discarded.

Verification
REQ-036 Memory model with 2-cycle latency, count=3; rd_req pulse -> rd_ack at T; addr 0 at T+1; count=3 at T+3; rd_valid at T+6,T+7,T+8 with rd_index 1,2,3; rd_last and done at T+8.
REQ-037 count=0 -> done at T+4, rd_valid never high, busy high T+1..T+4.
REQ-038 count=5 with rd_pause high for 2 cycles at T+5 -> indices 1..5 delivered in order, no duplicates, with a 2-cycle gap; rd_last on index 5.
REQ-039 wr_req and rd_req asserted in the same IDLE cycle (wr_addr=0, data=2) -> wr_ack first, then read acked; particle_count=2, two particles streamed.
REQ-040 wr_req raised during STREAM -> no wr_ack and mem_wren=0 until done; granted in the first IDLE cycle after.
REQ-041 count word=250 -> particle_count=219; rst_n pulsed low at stream index 4 -> outputs 0 immediately; no done; next rd_req restarts from address 0.
